// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: reset/write-enable levels,
// register widths, load-op encodings (shared with EX/MEM) and extend helpers.
package mem_wb_pkg;

   localparam int          REG_W      = 32;
   localparam int          REG_ADDR_W = 5;

   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

   typedef enum logic [2:0] {
      LOAD_LB  = 3'd0,
      LOAD_LBU = 3'd1,
      LOAD_LH  = 3'd2,
      LOAD_LHU = 3'd3,
      LOAD_LW  = 3'd4,
      LOAD_LWL = 3'd5,
      LOAD_LWR = 3'd6,
      LOAD_RSV = 3'd7
   } load_op_e;

   function automatic logic [31:0] ext8(
      input logic [7:0] b,
      input logic       s
   );
      return s ? {{24{b[7]}}, b} : {24'h0, b};
   endfunction

   function automatic logic [31:0] ext16(
      input logic [15:0] h,
      input logic        s
   );
      return s ? {{16{h[15]}}, h} : {16'h0, h};
   endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Big-endian load alignment and extension for LB/LBU/LH/LHU/LW/LWL/LWR.
// Ports: i_d raw word, i_rt old rt, i_off addr[1:0], i_op load kind;
//        o_data aligned result, o_misaligned illegal offset or reserved op.
module mem_wb_load_align
   import mem_wb_pkg::*;
(
   input  logic [REG_W-1:0] i_d,
   input  logic [REG_W-1:0] i_rt,
   input  logic [1:0]       i_off,
   input  logic [2:0]       i_op,
   output logic [REG_W-1:0] o_data,
   output logic             o_misaligned
);

   load_op_e    w_op;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_lwl;
   logic [31:0] w_lwr;

   assign w_op = load_op_e'(i_op);

   // Offset 0 addresses the most significant byte (big-endian).
   always_comb begin
      w_byte = i_d[31:24];
      unique case (i_off)
         2'd0: w_byte = i_d[31:24];
         2'd1: w_byte = i_d[23:16];
         2'd2: w_byte = i_d[15:8];
         2'd3: w_byte = i_d[7:0];
      endcase
   end

   assign w_half = i_off[1] ? i_d[15:0] : i_d[31:16];

   // LWL fills the upper bytes from memory, keeping low rt bytes.
   always_comb begin
      w_lwl = i_d;
      unique case (i_off)
         2'd0: w_lwl = i_d;
         2'd1: w_lwl = {i_d[23:0], i_rt[7:0]};
         2'd2: w_lwl = {i_d[15:0], i_rt[15:0]};
         2'd3: w_lwl = {i_d[7:0],  i_rt[23:0]};
      endcase
   end

   // LWR fills the lower bytes from memory, keeping high rt bytes.
   always_comb begin
      w_lwr = i_d;
      unique case (i_off)
         2'd0: w_lwr = {i_rt[31:8],  i_d[31:24]};
         2'd1: w_lwr = {i_rt[31:16], i_d[31:16]};
         2'd2: w_lwr = {i_rt[31:24], i_d[31:8]};
         2'd3: w_lwr = i_d;
      endcase
   end

   always_comb begin
      o_data       = ZERO_WORD;
      o_misaligned = 1'b0;
      unique case (w_op)
         LOAD_LB:  o_data = ext8(w_byte, 1'b1);
         LOAD_LBU: o_data = ext8(w_byte, 1'b0);
         LOAD_LH: begin
            o_data       = ext16(w_half, 1'b1);
            o_misaligned = i_off[0];
         end
         LOAD_LHU: begin
            o_data       = ext16(w_half, 1'b0);
            o_misaligned = i_off[0];
         end
         LOAD_LW: begin
            o_data       = i_d;
            o_misaligned = |i_off;
         end
         LOAD_LWL: o_data = w_lwl;
         LOAD_LWR: o_data = w_lwr;
         LOAD_RSV: o_misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; sole driver of regfile and HI/LO write ports.
// Ports: clk/rst, stall_mem/stall_wb/flush control, mem_* stage inputs,
//        wb_* registered write-back outputs, align_err one-cycle flag.
module mem_wb
   import mem_wb_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_mem,
   input  logic              stall_wb,
   input  logic              flush,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic              mem_wreg,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_is_load,
   input  logic [2:0]        mem_load_op,
   input  logic [1:0]        mem_addr_lo,
   input  logic [DATA_W-1:0] mem_rt_data,
   input  logic              mem_whilo,
   input  logic [DATA_W-1:0] mem_hi,
   input  logic [DATA_W-1:0] mem_lo,
   output logic [ADDR_W-1:0] wb_wd,
   output logic              wb_wreg,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              wb_whilo,
   output logic [DATA_W-1:0] wb_hi,
   output logic [DATA_W-1:0] wb_lo,
   output logic              align_err
);

   logic [DATA_W-1:0] w_ld_data;
   logic              w_ld_mis;
   logic              w_mis;
   logic [DATA_W-1:0] w_wdata;
   logic              w_bubble;

   logic [ADDR_W-1:0] r_wd;
   logic              r_wreg;
   logic [DATA_W-1:0] r_wdata;
   logic              r_whilo;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic              r_aerr;

   mem_wb_load_align u_align (
      .i_d          (mem_wdata),
      .i_rt         (mem_rt_data),
      .i_off        (mem_addr_lo),
      .i_op         (mem_load_op),
      .o_data       (w_ld_data),
      .o_misaligned (w_ld_mis)
   );

   assign w_mis    = mem_is_load & w_ld_mis;
   assign w_wdata  = mem_is_load ? w_ld_data : mem_wdata;
   // MEM stalled while WB moves on: WB must see an empty slot.
   assign w_bubble = flush | (stall_mem & ~stall_wb);

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         r_wd    <= '0;
         r_wreg  <= WRITE_DISABLE;
         r_wdata <= '0;
         r_whilo <= WRITE_DISABLE;
         r_hi    <= '0;
         r_lo    <= '0;
         r_aerr  <= 1'b0;
      end else if (w_bubble) begin
         r_wd    <= '0;
         r_wreg  <= WRITE_DISABLE;
         r_wdata <= '0;
         r_whilo <= WRITE_DISABLE;
         r_hi    <= '0;
         r_lo    <= '0;
         r_aerr  <= 1'b0;
      end else if (!stall_mem) begin
         // A misaligned load still occupies the slot but never writes rd.
         r_wd    <= mem_wd;
         r_wreg  <= mem_wreg & ~w_mis;
         r_wdata <= w_mis ? '0 : w_wdata;
         r_whilo <= mem_whilo;
         r_hi    <= mem_hi;
         r_lo    <= mem_lo;
         r_aerr  <= w_mis;
      end else begin
         // Held slot: the error pulse must not repeat.
         r_aerr  <= 1'b0;
      end
   end

   assign wb_wd     = r_wd;
   assign wb_wreg   = r_wreg;
   assign wb_wdata  = r_wdata;
   assign wb_whilo  = r_whilo;
   assign wb_hi     = r_hi;
   assign wb_lo     = r_lo;
   assign align_err = r_aerr;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: stimulus pushes hand-computed expectations,
// a monitor pops and compares after each clock edge.
module tb_mem_wb;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        aerr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_mem = 1'b0;
   logic        stall_wb = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  mem_wd = '0;
   logic        mem_wreg = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic        mem_is_load = 1'b0;
   logic [2:0]  mem_load_op = '0;
   logic [1:0]  mem_addr_lo = '0;
   logic [31:0] mem_rt_data = '0;
   logic        mem_whilo = 1'b0;
   logic [31:0] mem_hi = '0;
   logic [31:0] mem_lo = '0;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        wb_whilo;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;
   logic        align_err;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];

   mem_wb dut (
      .clk         (clk),
      .rst         (rst),
      .stall_mem   (stall_mem),
      .stall_wb    (stall_wb),
      .flush       (flush),
      .mem_wd      (mem_wd),
      .mem_wreg    (mem_wreg),
      .mem_wdata   (mem_wdata),
      .mem_is_load (mem_is_load),
      .mem_load_op (mem_load_op),
      .mem_addr_lo (mem_addr_lo),
      .mem_rt_data (mem_rt_data),
      .mem_whilo   (mem_whilo),
      .mem_hi      (mem_hi),
      .mem_lo      (mem_lo),
      .wb_wd       (wb_wd),
      .wb_wreg     (wb_wreg),
      .wb_wdata    (wb_wdata),
      .wb_whilo    (wb_whilo),
      .wb_hi       (wb_hi),
      .wb_lo       (wb_lo),
      .align_err   (align_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(
      input logic [4:0]  wd,
      input logic        wreg,
      input logic [31:0] wdata,
      input logic        whilo,
      input logic [31:0] hi,
      input logic [31:0] lo,
      input logic        aerr
   );
      exp_t e;
      e.wd = wd; e.wreg = wreg; e.wdata = wdata;
      e.whilo = whilo; e.hi = hi; e.lo = lo; e.aerr = aerr;
      return e;
   endfunction

   function automatic exp_t act();
      return mk(wb_wd, wb_wreg, wb_wdata, wb_whilo,
                wb_hi, wb_lo, align_err);
   endfunction

   // One cycle: drive inputs after the falling edge, queue the
   // value expected after the following rising edge.
   task automatic step(
      input logic        r,
      input logic        sm,
      input logic        sw,
      input logic        fl,
      input logic [4:0]  wd,
      input logic        wreg,
      input logic [31:0] wdata,
      input logic        ld,
      input logic [2:0]  op,
      input logic [1:0]  off,
      input logic [31:0] rt,
      input logic        whilo,
      input logic [31:0] hi,
      input logic [31:0] lo,
      input exp_t        e
   );
      @(negedge clk);
      #1;
      rst = r; stall_mem = sm; stall_wb = sw; flush = fl;
      mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
      mem_is_load = ld; mem_load_op = op; mem_addr_lo = off;
      mem_rt_data = rt; mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = act();
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL wb_out#%0d: got %h want %h", n_chk, a, e);
            end
         end
      end
   end

   localparam logic [31:0] D1 = 32'h80FF_7F01;
   localparam logic [31:0] D2 = 32'hAABB_CCDD;
   localparam logic [31:0] RT = 32'h1122_3344;
   localparam exp_t        Z  = '0;

   initial begin : stim
      exp_t held;
      #1;
      n_chk++;
      if (act() !== Z) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", act(), Z);
      end
      step(1,0,0,0, 5'd3,1,32'h1,0,0,0,0,0,0,0, Z);
      step(0,0,0,0, 5'd5,1,32'h1234_5678,0,0,0,0,0,0,0,
           mk(5,1,32'h1234_5678,0,0,0,0));
      step(0,0,0,0, 5'd6,1,D1,1,3'd0,2'd0,0,0,0,0,
           mk(6,1,32'hFFFF_FF80,0,0,0,0));
      step(0,0,0,0, 5'd7,1,D1,1,3'd1,2'd0,0,0,0,0,
           mk(7,1,32'h0000_0080,0,0,0,0));
      step(0,0,0,0, 5'd8,1,D1,1,3'd2,2'd2,0,0,0,0,
           mk(8,1,32'h0000_7F01,0,0,0,0));
      step(0,0,0,0, 5'd9,1,D1,1,3'd3,2'd0,0,0,0,0,
           mk(9,1,32'h0000_80FF,0,0,0,0));
      step(0,0,0,0, 5'd10,1,D1,1,3'd0,2'd3,0,0,0,0,
           mk(10,1,32'h0000_0001,0,0,0,0));
      step(0,0,0,0, 5'd11,1,D2,1,3'd5,2'd1,RT,0,0,0,
           mk(11,1,32'hBBCC_DD44,0,0,0,0));
      step(0,0,0,0, 5'd12,1,D2,1,3'd6,2'd1,RT,0,0,0,
           mk(12,1,32'h1122_AABB,0,0,0,0));
      step(0,0,0,0, 5'd13,1,D2,1,3'd4,2'd2,RT,0,0,0,
           mk(13,0,32'h0,0,0,0,1));
      step(0,0,0,0, 5'd14,1,32'hDEAD_BEEF,0,0,0,0,
           1,32'h1111_1111,32'h2222_2222,
           mk(14,1,32'hDEAD_BEEF,1,32'h1111_1111,32'h2222_2222,0));
      step(0,1,0,0, 5'd9,1,32'h5555_5555,0,0,0,0,
           1,32'h7,32'h8, Z);
      step(0,0,0,0, 5'd15,1,32'hCAFE_F00D,0,0,0,0,1,32'h3,32'h4,
           mk(15,1,32'hCAFE_F00D,1,32'h3,32'h4,0));
      held = mk(15,1,32'hCAFE_F00D,1,32'h3,32'h4,0);
      for (int i = 0; i < 3; i++)
         step(0,1,1,0, 5'd2,1,32'h9999_0000,0,0,0,0,0,0,0, held);
      step(0,0,0,0, 5'd16,1,D1,1,3'd2,2'd1,0,1,32'h5,32'h6,
           mk(16,0,32'h0,1,32'h5,32'h6,1));
      step(0,1,1,0, 5'd4,1,32'h1,0,0,0,0,0,0,0,
           mk(16,0,32'h0,1,32'h5,32'h6,0));
      step(0,0,0,0, 5'd17,1,D1,1,3'd7,2'd0,0,0,0,0,
           mk(17,0,32'h0,0,0,0,1));
      step(0,0,0,0, 5'd18,1,32'h5,0,0,0,0,0,0,0,
           mk(18,1,32'h5,0,0,0,0));
      step(0,0,0,1, 5'd20,1,32'h6,0,0,0,0,1,32'h1,32'h2, Z);
      step(0,0,0,0, 5'd19,1,32'h77,0,0,0,0,1,32'hA,32'hB,
           mk(19,1,32'h77,1,32'hA,32'hB,0));
      step(0,1,1,1, 5'd20,1,32'h6,0,0,0,0,1,32'h1,32'h2, Z);
      step(0,0,0,0, 5'd0,1,32'hABCD,0,0,0,0,0,0,0,
           mk(0,1,32'hABCD,0,0,0,0));
      step(0,0,0,0, 5'd20,1,D2,1,3'd6,2'd3,RT,0,0,0,
           mk(20,1,D2,0,0,0,0));
      step(0,0,0,0, 5'd21,1,D2,1,3'd5,2'd3,RT,0,0,0,
           mk(21,1,32'hDD22_3344,0,0,0,0));
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_chk++;
      if (act() !== Z) begin
         n_fail++;
         $display("FAIL async_reset: got %h want %h", act(), Z);
      end
      step(1,0,0,0, 5'd22,1,32'h42,0,0,0,0,0,0,0, Z);
      step(0,0,0,0, 5'd5,1,32'h1234_5678,0,0,0,0,0,0,0,
           mk(5,1,32'h1234_5678,0,0,0,0));
      step(0,0,0,0, 5'd0,0,32'h0,0,0,0,0,0,0,0, Z);
      for (int i = 0; i < 5 && q.size() > 0; i++)
         @(negedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
